// File: rtl/lhn_pipe_addsub_if.sv
// lhn_pipe_addsub_if
// Operand/result bundle for the pipelined add/subtract unit.
//   in_valid / in_ready   : operand beat handshake (source -> unit)
//   mode                  : 0 = add, 1 = subtract (y is inverted)
//   carryin               : carry into bit 0
//   x, y                  : operands, WIDTH bits
//   out_valid / out_ready : result handshake (unit -> consumer)
//   s                     : result, WIDTH bits
//   carryout, overflow    : carry out of the MSB, signed overflow
//   zero                  : result equals zero
// The master modport is the operand source / result consumer side,
// the slave modport is the arithmetic unit itself.
interface lhn_pipe_addsub_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             carryin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, mode, carryin, x, y, out_ready,
    input  in_ready, out_valid, s, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, mode, carryin, x, y, out_ready,
    output in_ready, out_valid, s, carryout, overflow, zero
  );
endinterface

// File: rtl/lhn_pipe_addsub.sv
// lhn_pipe_addsub
// Pipelined add/subtract unit. The operand width is cut into STAGES
// carry chunks of CHUNK = ceil(WIDTH/STAGES) bits; each stage ripples one
// chunk and registers it together with its carry, so the critical path
// is one chunk wide rather than WIDTH wide.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset, discards all in-flight beats
//   bus      : lhn_pipe_addsub_if.slave, operand and result handshakes
// Result {carryout, s} = x + (mode ? ~y : y) + carryin. Latency is STAGES
// cycles, throughput one beat per cycle, and a stalled output freezes the
// entire pipe.
module lhn_pipe_addsub #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  lhn_pipe_addsub_if.slave bus
);

  // Guard the divide so an illegal STAGES reaches the elaboration error
  // below instead of a divide-by-zero.
  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = (WIDTH + SAFE_STAGES - 1) / SAFE_STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH) begin : g_badParams
    $error("lhn_pipe_addsub: STAGES must lie in 1..WIDTH and WIDTH must be at least 1");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_xIn    [STAGES];
  logic [WIDTH-1:0] w_yyIn   [STAGES];
  logic [WIDTH-1:0] w_sumIn  [STAGES];
  logic [WIDTH-1:0] w_sumOut [STAGES];
  logic             w_cin    [STAGES];
  logic             w_cout   [STAGES];
  logic             w_vIn    [STAGES];
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_x      [STAGES];
  logic [WIDTH-1:0] r_yy     [STAGES];
  logic [WIDTH-1:0] r_sum    [STAGES];
  logic             r_carry  [STAGES];
  logic             r_valid  [STAGES];
  logic             r_ovf;
  logic             r_zero;

  // The whole pipe moves as one; a held result blocks every stage.
  assign w_adv        = !r_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = ((k + 1) * CHUNK < WIDTH) ? (k + 1) * CHUNK - 1 : WIDTH - 1;

    // Operands travel alongside the partial sum, so the bits a stage needs
    // arrive delayed by exactly k registers.
    if (k == 0) begin : g_first
      assign w_xIn[k]   = bus.x;
      assign w_yyIn[k]  = bus.mode ? ~bus.y : bus.y;
      assign w_sumIn[k] = '0;
      assign w_cin[k]   = bus.carryin;
      assign w_vIn[k]   = bus.in_valid && w_adv;
    end else begin : g_next
      assign w_xIn[k]   = r_x[k-1];
      assign w_yyIn[k]  = r_yy[k-1];
      assign w_sumIn[k] = r_sum[k-1];
      assign w_cin[k]   = r_carry[k-1];
      assign w_vIn[k]   = r_valid[k-1];
    end

    if (LO < WIDTH) begin : g_chunk
      localparam int CW = HI - LO + 1;
      logic [CW:0] w_chunk;

      assign w_chunk = {1'b0, w_xIn[k][HI:LO]} + {1'b0, w_yyIn[k][HI:LO]}
                     + (CW + 1)'(w_cin[k]);
      // Bits above this chunk are still zero in the partial sum, so the
      // new chunk can simply be OR-ed into place.
      assign w_sumOut[k] = w_sumIn[k] | (WIDTH'(w_chunk[CW-1:0]) << LO);
      assign w_cout[k]   = w_chunk[CW];
    end else begin : g_empty
      // Rounding CHUNK up can leave trailing stages with no bits at all;
      // they only delay the sum and carry by one register.
      assign w_sumOut[k] = w_sumIn[k];
      assign w_cout[k]   = w_cin[k];
    end
  end

  // Flags are formed from the finished sum entering the last register so
  // they are registered together with s.
  assign w_ovf  = (w_xIn[STAGES-1][WIDTH-1] == w_yyIn[STAGES-1][WIDTH-1])
               && (w_sumOut[STAGES-1][WIDTH-1] != w_xIn[STAGES-1][WIDTH-1]);
  assign w_zero = (w_sumOut[STAGES-1] == '0);

  // Data registers only load behind a valid beat, which keeps the last
  // result on the outputs while out_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]     <= '0;
        r_yy[k]    <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_valid[k] <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_vIn[k];
        if (w_vIn[k]) begin
          r_x[k]     <= w_xIn[k];
          r_yy[k]    <= w_yyIn[k];
          r_sum[k]   <= w_sumOut[k];
          r_carry[k] <= w_cout[k];
        end
      end
      if (w_vIn[STAGES-1]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.s         = r_sum[STAGES-1];
  assign bus.carryout  = r_carry[STAGES-1];
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_lhn_pipe_addsub.sv
// tb_lhn_pipe_addsub
// Drives three configurations of lhn_pipe_addsub side by side:
//   A : WIDTH=8, STAGES=4 (overflow, subtract, backpressure, reset in flight)
//   B : WIDTH=7, STAGES=5 (chunks of 2,2,2,1 plus an empty pass-through stage)
//   C : WIDTH=7, STAGES=1 (single registered adder)
// The stimulus process pushes hand-computed results into per-DUT queues;
// independent monitors pop and compare whenever a DUT presents a result.
module tb_lhn_pipe_addsub;

  typedef struct {
    logic       mode;
    logic       cin;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] s;
    logic       co;
    logic       ovf;
    logic       z;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ovf;
    logic       z;
    int         cyc;
  } item_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cycle   = 0;
  int   compared   = 0;
  int   mismatched = 0;

  vec_t  vecA [16];
  vec_t  vecB [6];
  item_t qA [$];
  item_t qB [$];
  item_t qC [$];

  lhn_pipe_addsub_if #(.WIDTH(8)) ifA ();
  lhn_pipe_addsub_if #(.WIDTH(7)) ifB ();
  lhn_pipe_addsub_if #(.WIDTH(7)) ifC ();

  lhn_pipe_addsub #(.WIDTH(8), .STAGES(4)) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA));
  lhn_pipe_addsub #(.WIDTH(7), .STAGES(5)) dutB (.clk(clk), .reset_n(reset_n), .bus(ifB));
  lhn_pipe_addsub #(.WIDTH(7), .STAGES(1)) dutC (.clk(clk), .reset_n(reset_n), .bus(ifC));

  // Free-running clock and cycle counter used for latency expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic vec_t mkVec(input logic m, input logic c, input logic [7:0] x,
                                 input logic [7:0] y, input logic [7:0] s,
                                 input logic co, input logic ovf, input logic z);
    vec_t v;
    v.mode = m; v.cin = c; v.x = x; v.y = y;
    v.s = s; v.co = co; v.ovf = ovf; v.z = z;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs change 1ns after the rising edge, and the
  // expected results are queued only for beats the unit should accept.
  task automatic applyStimulus(input bit vA, input vec_t a, input bit rdyA, input bit expRdyA,
                               input bit latOn, input bit vB, input vec_t b, input bit rdyC);
    @(posedge clk);
    #1;
    ifA.in_valid = vA;  ifA.mode = a.mode; ifA.carryin = a.cin;
    ifA.x = a.x;        ifA.y = a.y;       ifA.out_ready = rdyA;
    ifB.in_valid = vB;  ifB.mode = b.mode; ifB.carryin = b.cin;
    ifB.x = b.x[6:0];   ifB.y = b.y[6:0];  ifB.out_ready = 1'b1;
    ifC.in_valid = vB;  ifC.mode = b.mode; ifC.carryin = b.cin;
    ifC.x = b.x[6:0];   ifC.y = b.y[6:0];  ifC.out_ready = rdyC;
    #1;
    if (vA) begin
      checkOutput("A_in_ready", 32'(ifA.in_ready), 32'(expRdyA));
      if (expRdyA)
        qA.push_back('{s: a.s, co: a.co, ovf: a.ovf, z: a.z, cyc: (latOn ? cycle + 4 : -1)});
    end
    if (vB) begin
      checkOutput("B_in_ready", 32'(ifB.in_ready), 32'd1);
      checkOutput("C_in_ready", 32'(ifC.in_ready), 32'd1);
      qB.push_back('{s: b.s, co: b.co, ovf: b.ovf, z: b.z, cyc: cycle + 5});
      qC.push_back('{s: b.s, co: b.co, ovf: b.ovf, z: b.z, cyc: cycle + 1});
    end
  endtask

  task automatic drainAll(input string tag);
    int waited;
    waited = 0;
    applyStimulus(1'b0, vecA[0], 1'b1, 1'b1, 1'b0, 1'b0, vecB[0], 1'b1);
    while ((qA.size() + qB.size() + qC.size()) != 0 && waited < 60) begin
      @(posedge clk);
      waited++;
    end
    checkOutput({tag, "_pending"}, 32'(qA.size() + qB.size() + qC.size()), 32'd0);
  endtask

  // Monitors: compare every presented result against the queue head, pop
  // on transfer, and check latency where the bench asked for it.
  always @(negedge clk) begin
    if (reset_n && ifA.out_valid === 1'b1) begin
      if (qA.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL A_unexpected: got out_valid=1, required no pending result (t=%0t)", $time);
      end else begin
        checkOutput("A_result", 32'({ifA.s, ifA.carryout, ifA.overflow, ifA.zero}),
                    32'({qA[0].s, qA[0].co, qA[0].ovf, qA[0].z}));
        if (ifA.out_ready === 1'b1) begin
          if (qA[0].cyc >= 0) checkOutput("A_latency", 32'(cycle), 32'(qA[0].cyc));
          void'(qA.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && ifB.out_valid === 1'b1) begin
      if (qB.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL B_unexpected: got out_valid=1, required no pending result (t=%0t)", $time);
      end else begin
        checkOutput("B_result", 32'({1'b0, ifB.s, ifB.carryout, ifB.overflow, ifB.zero}),
                    32'({qB[0].s, qB[0].co, qB[0].ovf, qB[0].z}));
        if (ifB.out_ready === 1'b1) begin
          checkOutput("B_latency", 32'(cycle), 32'(qB[0].cyc));
          void'(qB.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && ifC.out_valid === 1'b1) begin
      if (qC.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL C_unexpected: got out_valid=1, required no pending result (t=%0t)", $time);
      end else begin
        checkOutput("C_result", 32'({1'b0, ifC.s, ifC.carryout, ifC.overflow, ifC.zero}),
                    32'({qC[0].s, qC[0].co, qC[0].ovf, qC[0].z}));
        if (ifC.out_ready === 1'b1) begin
          checkOutput("C_latency", 32'(cycle), 32'(qC[0].cyc));
          void'(qC.pop_front());
        end
      end
    end
  end

  // Watchdog so a wedged pipe still produces a summary.
  initial begin
    #100000;
    mismatched++;
    $display("[TB] FAIL watchdog: got no completion, required finish before 100000ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    //                  mode cin  x      y      s      co    ovf   z
    vecA[0]  = mkVec(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    vecA[1]  = mkVec(1'b1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    vecA[2]  = mkVec(1'b1, 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0);
    vecA[3]  = mkVec(1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    vecA[4]  = mkVec(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    vecA[5]  = mkVec(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    vecA[6]  = mkVec(1'b1, 1'b0, 8'h10, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0);
    vecA[7]  = mkVec(1'b1, 1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
    vecA[8]  = mkVec(1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    vecA[9]  = mkVec(1'b0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 1'b0);
    vecA[10] = mkVec(1'b0, 1'b0, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
    vecA[11] = mkVec(1'b0, 1'b1, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1);
    vecA[12] = mkVec(1'b1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    vecA[13] = mkVec(1'b0, 1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0);
    vecA[14] = mkVec(1'b1, 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0);
    vecA[15] = mkVec(1'b0, 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0);
    // 7-bit vectors for B and C
    vecB[0]  = mkVec(1'b0, 1'b0, 8'h7F, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    vecB[1]  = mkVec(1'b0, 1'b1, 8'h7F, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    vecB[2]  = mkVec(1'b1, 1'b1, 8'h10, 8'h20, 8'h70, 1'b0, 1'b0, 1'b0);
    vecB[3]  = mkVec(1'b0, 1'b0, 8'h3F, 8'h01, 8'h40, 1'b0, 1'b1, 1'b0);
    vecB[4]  = mkVec(1'b1, 1'b1, 8'h40, 8'h01, 8'h3F, 1'b1, 1'b1, 1'b0);
    vecB[5]  = mkVec(1'b0, 1'b0, 8'h2A, 8'h15, 8'h3F, 1'b0, 1'b0, 1'b0);

    ifA.in_valid = 1'b0; ifA.mode = 1'b0; ifA.carryin = 1'b0; ifA.x = '0; ifA.y = '0; ifA.out_ready = 1'b1;
    ifB.in_valid = 1'b0; ifB.mode = 1'b0; ifB.carryin = 1'b0; ifB.x = '0; ifB.y = '0; ifB.out_ready = 1'b1;
    ifC.in_valid = 1'b0; ifC.mode = 1'b0; ifC.carryin = 1'b0; ifC.x = '0; ifC.y = '0; ifC.out_ready = 1'b1;

    // Reset state: no result, cleared outputs and flags, ready for input.
    #3;
    checkOutput("A_reset_out", 32'({ifA.out_valid, ifA.s, ifA.carryout, ifA.overflow, ifA.zero}), 32'd0);
    checkOutput("B_reset_out", 32'({ifB.out_valid, ifB.s, ifB.carryout, ifB.overflow, ifB.zero}), 32'd0);
    checkOutput("C_reset_out", 32'({ifC.out_valid, ifC.s, ifC.carryout, ifC.overflow, ifC.zero}), 32'd0);
    checkOutput("reset_in_ready", 32'({ifA.in_ready, ifB.in_ready, ifC.in_ready}), 32'h7);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    $display("[TB] back-to-back stream with latency checks");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, vecA[i], 1'b1, 1'b1, 1'b1, (i < 6), vecB[i % 6], 1'b1);
    drainAll("stream");

    $display("[TB] backpressure on A");
    begin
      int idx;
      bit stall;
      idx = 0;
      for (int t = 0; t < 40 && idx < 8; t++) begin
        stall = (t >= 6 && t <= 10);
        applyStimulus(1'b1, vecA[8 + idx], !stall, !stall, 1'b0, 1'b0, vecB[0], 1'b1);
        if (stall) checkOutput("A_stall_valid", 32'(ifA.out_valid), 32'd1);
        else idx++;
      end
      checkOutput("A_stream_sent", 32'(idx), 32'd8);
    end
    drainAll("backpressure");

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b1, vecA[0], 1'b1, 1'b1, 1'b1, 1'b0, vecB[0], 1'b1);
    applyStimulus(1'b1, vecA[1], 1'b1, 1'b1, 1'b1, 1'b1, vecB[2], 1'b0);
    applyStimulus(1'b1, vecA[2], 1'b1, 1'b1, 1'b1, 1'b0, vecB[0], 1'b0);
    @(posedge clk);
    #1;
    ifA.in_valid = 1'b0; ifB.in_valid = 1'b0; ifC.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    qA.delete(); qB.delete(); qC.delete();
    #1;
    checkOutput("A_async_reset", 32'({ifA.out_valid, ifA.s, ifA.carryout, ifA.overflow, ifA.zero}), 32'd0);
    checkOutput("B_async_reset", 32'({ifB.out_valid, ifB.s, ifB.carryout, ifB.overflow, ifB.zero}), 32'd0);
    checkOutput("C_async_reset", 32'({ifC.out_valid, ifC.s, ifC.carryout, ifC.overflow, ifC.zero}), 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    ifC.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      checkOutput("no_stale_valid", 32'({ifA.out_valid, ifB.out_valid, ifC.out_valid}), 32'd0);
    end
    applyStimulus(1'b1, vecA[3], 1'b1, 1'b1, 1'b1, 1'b1, vecB[4], 1'b1);
    drainAll("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
